// File: rtl/prep_lut_sched.sv
// Sequencing controller for the activation-LUT preprocessor: packs activations into triples,
// pulses the preprocessor register enable and holds the LUT-valid lookup window per group.
// Optional build macro: PREP_SCHED_PREFETCH_EN (load the next triple during the lookup window).
module prep_lut_sched #(
    parameter int ACT_W = 32,
    parameter int CNT_W = 16,
    parameter int LK_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cfg_acts_i,
    input  logic [LK_W-1:0]  cfg_lookups_i,
    input  logic             act_valid_i,
    input  logic [ACT_W-1:0] act_data_i,
    output logic             act_ready_o,
    output logic [ACT_W-1:0] act0_o,
    output logic [ACT_W-1:0] act1_o,
    output logic [ACT_W-1:0] act2_o,
    output logic             dff_en_o,
    output logic             lut_valid_o,
    input  logic             lut_stall_i,
    output logic [LK_W-1:0]  lookup_idx_o,
    output logic [CNT_W-1:0] group_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_LOOKUP = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       fill_q, fill_d;
    logic [LK_W-1:0]  lk_num_q, lk_num_d;
    logic [LK_W-1:0]  lk_idx_q, lk_idx_d;
    logic [CNT_W-1:0] grp_q, grp_d;
    logic [ACT_W-1:0] act0_q, act0_d;
    logic [ACT_W-1:0] act1_q, act1_d;
    logic [ACT_W-1:0] act2_q, act2_d;
    logic             ready_q, ready_d;
    logic             dff_en_q, dff_en_d;
    logic             lut_valid_q, lut_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept_s;
    logic             grp_full_s;
    logic             grp_left_s;
    logic             ready_win_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        fill_d   = fill_q;
        lk_num_d = lk_num_q;
        lk_idx_d = lk_idx_q;
        grp_d    = grp_q;
        act0_d   = act0_q;
        act1_d   = act1_q;
        act2_d   = act2_q;

        // ready_q is only ever set with fill < 3 and activations remaining
        accept_s = act_valid_i && ready_q;
        if (accept_s) begin
            if (fill_q == 2'd0) begin
                act0_d = act_data_i;
                act1_d = {ACT_W{1'b0}};
                act2_d = {ACT_W{1'b0}};
            end else if (fill_q == 2'd1) begin
                act1_d = act_data_i;
            end else begin
                act2_d = act_data_i;
            end
            fill_d = fill_q + 2'd1;
            if (rem_q != {CNT_W{1'b0}}) begin
                rem_d = rem_q - CNT_W'(1);
            end else begin
                rem_d = rem_q;
            end
        end else begin
            fill_d = fill_q;
        end

        // A group is complete when three lanes are filled or the vector ran out
        grp_full_s = (fill_d == 2'd3) || ((rem_d == {CNT_W{1'b0}}) && (fill_d != 2'd0));
        grp_left_s = (rem_d != {CNT_W{1'b0}}) || (fill_d != 2'd0);

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rem_d    = cfg_acts_i;
                    fill_d   = 2'd0;
                    grp_d    = {CNT_W{1'b0}};
                    lk_idx_d = {LK_W{1'b0}};
                    act0_d   = {ACT_W{1'b0}};
                    act1_d   = {ACT_W{1'b0}};
                    act2_d   = {ACT_W{1'b0}};
                    lk_num_d = (cfg_lookups_i == {LK_W{1'b0}}) ? LK_W'(1) : cfg_lookups_i;
                    state_d  = (cfg_acts_i != {CNT_W{1'b0}}) ? ST_LOAD : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (grp_full_s) begin
                    state_d = ST_LATCH;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LATCH: begin
                fill_d   = 2'd0;
                lk_idx_d = {LK_W{1'b0}};
                state_d  = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (!lut_stall_i) begin
                    if (lk_idx_q == (lk_num_q - LK_W'(1))) begin
                        lk_idx_d = {LK_W{1'b0}};
                        if (grp_left_s) begin
                            grp_d   = grp_q + CNT_W'(1);
                            state_d = grp_full_s ? ST_LATCH : ST_LOAD;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        lk_idx_d = lk_idx_q + LK_W'(1);
                    end
                end else begin
                    lk_idx_d = lk_idx_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PREP_SCHED_PREFETCH_EN
        ready_win_s = (state_d == ST_LOAD) || (state_d == ST_LOOKUP);
`else
        ready_win_s = (state_d == ST_LOAD);
`endif
        ready_d     = ready_win_s && (fill_d != 2'd3) && (rem_d != {CNT_W{1'b0}});
        dff_en_d    = (state_d == ST_LATCH);
        lut_valid_d = (state_d == ST_LOOKUP);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            rem_q       <= {CNT_W{1'b0}};
            fill_q      <= 2'd0;
            lk_num_q    <= LK_W'(1);
            lk_idx_q    <= {LK_W{1'b0}};
            grp_q       <= {CNT_W{1'b0}};
            act0_q      <= {ACT_W{1'b0}};
            act1_q      <= {ACT_W{1'b0}};
            act2_q      <= {ACT_W{1'b0}};
            ready_q     <= 1'b0;
            dff_en_q    <= 1'b0;
            lut_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            fill_q      <= fill_d;
            lk_num_q    <= lk_num_d;
            lk_idx_q    <= lk_idx_d;
            grp_q       <= grp_d;
            act0_q      <= act0_d;
            act1_q      <= act1_d;
            act2_q      <= act2_d;
            ready_q     <= ready_d;
            dff_en_q    <= dff_en_d;
            lut_valid_q <= lut_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign act_ready_o  = ready_q;
    assign act0_o       = act0_q;
    assign act1_o       = act1_q;
    assign act2_o       = act2_q;
    assign dff_en_o     = dff_en_q;
    assign lut_valid_o  = lut_valid_q;
    assign lookup_idx_o = lk_idx_q;
    assign group_idx_o  = grp_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: doc/prep_lut_sched.md
# prep_lut_sched

Sequencing controller for the activation-LUT preprocessor stage of the BitNet CiM accelerator.
- Accepts a stream of 32-bit signed activations over a valid/ready handshake and packs them into triples on `act0_o`/`act1_o`/`act2_o`.
- Pulses the preprocessor register enable once per triple.
- Then holds a LUT-valid window for a programmable number of lookup cycles, during which the weight-array side consumes the 16 registered LUT entries.
- Sits between the activation buffer and the preprocessor/CiM lookup datapath and is started once per activation vector.

## Interface
Parameters:
- `ACT_W`, 32, activation width.
- `CNT_W`, 16, width of activation count and group index.
- `LK_W`, 8, width of lookup-cycle count.

Ports:
- `clk`, in, 1, single clock.
- `rst_n_i`, in, 1, reset: one clock; reset is synchronous and active-low.
- `start_i`, in, 1, start one vector; ignored unless in IDLE.
- `cfg_acts_i`, in, CNT_W, total activations in the vector; sampled on accepted start.
- `cfg_lookups_i`, in, LK_W, lookup cycles per group; sampled on accepted start; 0 is treated as 1.
- `act_valid_i`, in, 1, activation available.
- `act_data_i`, in, ACT_W, activation value.
- `act_ready_o`, out, 1, controller accepts `act_data_i` this cycle.
- `act0_o`, `act1_o`, `act2_o`, out, ACT_W each, packed triple to the preprocessor.
- `dff_en_o`, out, 1, preprocessor register enable.
- `lut_valid_o`, out, 1, preprocessor LUT outputs valid for lookup.
- `lut_stall_i`, in, 1, consumer stall; freezes the lookup counter.
- `lookup_idx_o`, out, LK_W, current lookup cycle index.
- `group_idx_o`, out, CNT_W, current group index.
- `busy_o`, out, 1, not in IDLE.
- `done_o`, out, 1, one-cycle pulse at vector end.

## Operation
- States: IDLE, LOAD, LATCH, LOOKUP, DONE.
- Number of groups = ceil(cfg_acts/3).
- Fill target per group = min(3, activations remaining).
- IDLE:
  - `start_i` with cfg_acts≠0 → LOAD; registers and clears fill count, group_idx and act regs.
  - `start_i` with cfg_acts=0 → DONE.
- LOAD:
  - `act_ready_o`=1 while fill < target.
  - Each accept (valid&&ready) writes act0, then act1, then act2 in arrival order.
  - Lanes beyond the target are forced to 0 (final partial group zero-padded).
  - Fill reaches target → LATCH.
- LATCH: `dff_en_o`=1 for exactly one cycle; act*_o stable; → LOOKUP.
- LOOKUP:
  - `lut_valid_o`=1; lookup_idx counts 0..L-1, advancing only when `lut_stall_i`=0.
  - After the non-stalled cycle with idx=L-1: if groups remain, group_idx+1, clear fill (unless prefetched, see Configuration), → LOAD; else → DONE.
- DONE: `done_o`=1 for one cycle → IDLE.
- Arithmetic:
  - Remaining-activation counter is CNT_W bits, decremented per accept, never underflows.
  - Group and lookup counters wrap only by state reset, never arithmetically.
- `start_i` while busy: ignored, no cfg change.
- `act_valid_i` outside accept windows: not consumed (`act_ready_o`=0).
- Reset mid-operation: next edge with `rst_n_i`=0 forces IDLE and clears all counters; any partially loaded triple is discarded.

## Timing
- Reset values: `act_ready_o`=0, `act0_o`/`act1_o`/`act2_o`=0, `dff_en_o`=0, `lut_valid_o`=0, `lookup_idx_o`=0, `group_idx_o`=0, `busy_o`=0, `done_o`=0.
- All outputs are registered or decoded from registered state; no combinational path from `act_valid_i` or `lut_stall_i` to any output.
- start → `act_ready_o`: 1 cycle.
- Third accept edge → `dff_en_o` high the next cycle.
- `dff_en_o` high → `lut_valid_o` high the following cycle, aligned with the preprocessor register output.
- Minimum per group without prefetch: 3 (load) + 1 (latch) + L (lookup) cycles.
- Last lookup cycle → `done_o` the next cycle; `busy_o` falls together with `done_o`.

## Configuration
- `PREP_SCHED_PREFETCH_EN` defined:
  - In LOOKUP, `act_ready_o`=1 while fill < next-group target and groups remain; act regs load for the next group (safe because the preprocessor outputs are registered).
  - At lookup end, a full fill → LATCH directly, skipping LOAD.
  - Steady state is 1+L cycles/group.
  - `dff_en_o` is still only asserted in LATCH.
- Undefined: `act_ready_o` is asserted only in LOAD.

## Test plan
- cfg_acts=6, cfg_lookups=4, continuous valid, data 1..6 → two LATCH pulses with triples (1,2,3),(4,5,6); 4 `lut_valid_o` cycles each; `done_o` once; group_idx 0 then 1.
- cfg_acts=4, data 10,20,30,-5 → second triple (-5,0,0); two groups; `done_o` after second lookup window.
- cfg_acts=0, start → `done_o` pulse 1 cycle later, `act_ready_o` never high, no `dff_en_o`.
- cfg_lookups=3, `lut_stall_i` high for 2 cycles mid-window → `lut_valid_o` high 5 cycles; lookup_idx holds during stall, reaches 2.
- `rst_n_i` low after 2 accepts of a triple → next cycle all outputs at reset values; a new start with data 7,8,9 latches (7,8,9).
- With `PREP_SCHED_PREFETCH_EN`, cfg_acts=9, cfg_lookups=4, continuous valid → LATCH-to-LATCH spacing 5 cycles after the first group; 9 activations accepted total.
